// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage between EX/MB and writeback
//
// Turns the instruction held in the EX/MB register into at most one data
// memory access, or passes non-memory results straight to writeback.
// Handles alignment checking, store lane masking and replication, load lane
// extraction with sign/zero extension, access timeout and trap reporting.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_mb__*              instruction from the EX/MB register
//   dmem_req/we/addr/     data memory request; held stable while BUSY
//   wmask/wdata
//   dmem_ack/rdata        data memory response (rdata valid with ack only)
//   mb_stall              hold the EX/MB register upstream
//   mb_wb__*              writeback pulse, destination and data
//   mb_if__trap_taken     one-cycle trap pulse
//   mb_ex__trap_src       trap cause (4/6 misaligned, 5/7 access fault)
//   mb_ex__dmem_addr      faulting address
//   mb_ex__instret        one-cycle retire pulse
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mb__valid,
  input  logic [31:0] ex_mb__alu_y,
  input  logic [31:0] ex_mb__rs2_rdata,
  input  logic        ex_mb__mem_read,
  input  logic        ex_mb__mem_write,
  input  logic [2:0]  ex_mb__mem_funct3,
  input  logic [4:0]  ex_mb__rd_addr,
  input  logic        ex_mb__rd_wen,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mb_stall,
  output logic        mb_wb__valid,
  output logic        mb_wb__rd_wen,
  output logic [4:0]  mb_wb__rd_addr,
  output logic [31:0] mb_wb__rd_wdata,
  output logic        mb_if__trap_taken,
  output logic [4:0]  mb_ex__trap_src,
  output logic [31:0] mb_ex__dmem_addr,
  output logic        mb_ex__instret
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [4:0] CAUSE_LD_MISALIGN = 5'd4;
  localparam logic [4:0] CAUSE_LD_FAULT    = 5'd5;
  localparam logic [4:0] CAUSE_ST_MISALIGN = 5'd6;
  localparam logic [4:0] CAUSE_ST_FAULT    = 5'd7;

  logic [0:0]  state;
  logic [7:0]  tmo_cnt;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic        lat_load;
  logic [4:0]  lat_rd_addr;
  logic        lat_rd_wen;

  logic        accept;
  logic        is_mem;
  logic        size_b;
  logic        size_h;
  logic        misaligned;
  logic        start_access;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic [31:0] ld_shifted;
  logic [31:0] ld_data;

  // The instruction sitting in EX/MB during a trap pulse is flushed.
  assign accept = ex_mb__valid & ~mb_if__trap_taken;
  assign is_mem = ex_mb__mem_read | ex_mb__mem_write;

  // Reserved funct3 encodings fall through to word size.
  assign size_b = (ex_mb__mem_funct3 == 3'b000) | (ex_mb__mem_funct3 == 3'b100);
  assign size_h = (ex_mb__mem_funct3 == 3'b001) | (ex_mb__mem_funct3 == 3'b101);

  always_comb begin
    misaligned = 1'b0;
    if (size_h) begin
      misaligned = ex_mb__alu_y[0];
    end else if (!size_b) begin
      misaligned = |ex_mb__alu_y[1:0];
    end
  end

  assign start_access = (state == S_IDLE) & accept & is_mem & ~misaligned;

  always_comb begin
    mb_stall = 1'b0;
    if (state == S_IDLE) begin
      mb_stall = start_access;
    end else begin
      mb_stall = ~dmem_ack;
    end
  end

  // Store lanes: byte/half data is replicated so the memory can pick the
  // lane selected by the mask without any further shifting.
  always_comb begin
    st_wmask = 4'b1111;
    st_wdata = ex_mb__rs2_rdata;
    if (size_b) begin
      st_wmask = 4'b0001 << ex_mb__alu_y[1:0];
      st_wdata = {4{ex_mb__rs2_rdata[7:0]}};
    end else if (size_h) begin
      st_wmask = 4'b0011 << ex_mb__alu_y[1:0];
      st_wdata = {2{ex_mb__rs2_rdata[15:0]}};
    end
  end

  // Load lane extraction uses the byte offset latched at access start.
  assign ld_shifted = dmem_rdata >> {lat_addr[1:0], 3'b000};

  always_comb begin
    ld_data = dmem_rdata;
    case (lat_funct3)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b100:  ld_data = {24'h000000, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b101:  ld_data = {16'h0000, ld_shifted[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      tmo_cnt           <= 8'd0;
      lat_funct3        <= 3'b000;
      lat_addr          <= 32'd0;
      lat_load          <= 1'b0;
      lat_rd_addr       <= 5'd0;
      lat_rd_wen        <= 1'b0;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= 32'd0;
      dmem_wmask        <= 4'b0000;
      dmem_wdata        <= 32'd0;
      mb_wb__valid      <= 1'b0;
      mb_wb__rd_wen     <= 1'b0;
      mb_wb__rd_addr    <= 5'd0;
      mb_wb__rd_wdata   <= 32'd0;
      mb_if__trap_taken <= 1'b0;
      mb_ex__trap_src   <= 5'd0;
      mb_ex__dmem_addr  <= 32'd0;
      mb_ex__instret    <= 1'b0;
    end else begin
      // Pulse outputs default low; destination write enable only accompanies
      // a writeback pulse.
      mb_wb__valid      <= 1'b0;
      mb_wb__rd_wen     <= 1'b0;
      mb_if__trap_taken <= 1'b0;
      mb_ex__instret    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              mb_wb__valid    <= 1'b1;
              mb_wb__rd_wen   <= ex_mb__rd_wen;
              mb_wb__rd_addr  <= ex_mb__rd_addr;
              mb_wb__rd_wdata <= ex_mb__alu_y;
              mb_ex__instret  <= 1'b1;
            end else if (misaligned) begin
              mb_if__trap_taken <= 1'b1;
              mb_ex__trap_src   <= ex_mb__mem_write ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
              mb_ex__dmem_addr  <= ex_mb__alu_y;
            end else begin
              state       <= S_BUSY;
              tmo_cnt     <= 8'd0;
              dmem_req    <= 1'b1;
              dmem_we     <= ex_mb__mem_write;
              dmem_addr   <= {ex_mb__alu_y[31:2], 2'b00};
              dmem_wmask  <= st_wmask;
              dmem_wdata  <= st_wdata;
              lat_funct3  <= ex_mb__mem_funct3;
              lat_addr    <= ex_mb__alu_y;
              lat_load    <= ~ex_mb__mem_write;
              lat_rd_addr <= ex_mb__rd_addr;
              lat_rd_wen  <= ex_mb__rd_wen;
            end
          end
        end

        S_BUSY: begin
          // Ack is checked first so an ack arriving on the last timeout
          // cycle still retires normally.
          if (dmem_ack) begin
            state          <= S_IDLE;
            dmem_req       <= 1'b0;
            mb_wb__valid   <= 1'b1;
            mb_wb__rd_addr <= lat_rd_addr;
            mb_ex__instret <= 1'b1;
            if (lat_load) begin
              mb_wb__rd_wen   <= lat_rd_wen;
              mb_wb__rd_wdata <= ld_data;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state             <= S_IDLE;
            dmem_req          <= 1'b0;
            mb_if__trap_taken <= 1'b1;
            mb_ex__trap_src   <= lat_load ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
            mb_ex__dmem_addr  <= lat_addr;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        default: begin
          state    <= S_IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized bench for mem_stage
module tb_mem_stage;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        ex_mb__valid;
  logic [31:0] ex_mb__alu_y;
  logic [31:0] ex_mb__rs2_rdata;
  logic        ex_mb__mem_read;
  logic        ex_mb__mem_write;
  logic [2:0]  ex_mb__mem_funct3;
  logic [4:0]  ex_mb__rd_addr;
  logic        ex_mb__rd_wen;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mb_stall;
  logic        mb_wb__valid;
  logic        mb_wb__rd_wen;
  logic [4:0]  mb_wb__rd_addr;
  logic [31:0] mb_wb__rd_wdata;
  logic        mb_if__trap_taken;
  logic [4:0]  mb_ex__trap_src;
  logic [31:0] mb_ex__dmem_addr;
  logic        mb_ex__instret;

  int tests = 0;
  int fails = 0;
  int last_stall;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mb__valid(ex_mb__valid), .ex_mb__alu_y(ex_mb__alu_y),
    .ex_mb__rs2_rdata(ex_mb__rs2_rdata), .ex_mb__mem_read(ex_mb__mem_read),
    .ex_mb__mem_write(ex_mb__mem_write), .ex_mb__mem_funct3(ex_mb__mem_funct3),
    .ex_mb__rd_addr(ex_mb__rd_addr), .ex_mb__rd_wen(ex_mb__rd_wen),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mb_stall(mb_stall), .mb_wb__valid(mb_wb__valid), .mb_wb__rd_wen(mb_wb__rd_wen),
    .mb_wb__rd_addr(mb_wb__rd_addr), .mb_wb__rd_wdata(mb_wb__rd_wdata),
    .mb_if__trap_taken(mb_if__trap_taken), .mb_ex__trap_src(mb_ex__trap_src),
    .mb_ex__dmem_addr(mb_ex__dmem_addr), .mb_ex__instret(mb_ex__instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes from funct3 (unknown codes are words).
  function automatic int m_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] y);
    int s;
    int m;
    s = m_size(f3);
    m = ((1 << s) - 1) << (y % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int s;
    s = m_size(f3);
    if (s == 1) return (d % 256) * 32'h0101_0101;
    if (s == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] y,
                                         input logic [31:0] rdata);
    longint v;
    longint span;
    int s;
    s = m_size(f3);
    v = rdata;
    v = v >> (8 * (y % 4));
    if (s < 4) begin
      span = longint'(1) << (8 * s);
      v = v % span;
      if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2) v = v - span;
    end
    return v[31:0];
  endfunction

  task automatic drive_idle();
    ex_mb__valid = 1'b0;
    ex_mb__mem_read = 1'b0;
    ex_mb__mem_write = 1'b0;
  endtask

  // Presents one instruction at a negedge, runs it to completion against the
  // model, and returns at a negedge with the stage idle again.
  task automatic exec(input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] y, input logic [31:0] rs2,
                      input logic [4:0] ra, input bit rw, input int ack_dly,
                      input logic [31:0] rdata, input bit probe);
    bit mem;
    bit al;
    bit done;
    mem = rd | wr;
    al = (y % m_size(f3)) == 0;
    ex_mb__valid = 1'b1;
    ex_mb__mem_read = rd;
    ex_mb__mem_write = wr;
    ex_mb__mem_funct3 = f3;
    ex_mb__alu_y = y;
    ex_mb__rs2_rdata = rs2;
    ex_mb__rd_addr = ra;
    ex_mb__rd_wen = rw;
    #1;
    chk("stall_present", 32'(mb_stall), 32'(mem && al));
    last_stall = mb_stall ? 1 : 0;
    if (!mem) begin
      @(negedge clk);
      drive_idle();
      chk("alu_wb_valid", 32'(mb_wb__valid), 1);
      chk("alu_wdata", mb_wb__rd_wdata, y);
      chk("alu_rd_addr", 32'(mb_wb__rd_addr), 32'(ra));
      chk("alu_rd_wen", 32'(mb_wb__rd_wen), 32'(rw));
      chk("alu_instret", 32'(mb_ex__instret), 1);
      chk("alu_no_trap", 32'(mb_if__trap_taken), 0);
    end else if (!al) begin
      @(negedge clk);
      chk("mis_trap", 32'(mb_if__trap_taken), 1);
      chk("mis_src", 32'(mb_ex__trap_src), wr ? 6 : 4);
      chk("mis_addr", mb_ex__dmem_addr, y);
      chk("mis_no_wb", 32'(mb_wb__valid), 0);
      chk("mis_no_wen", 32'(mb_wb__rd_wen), 0);
      chk("mis_no_instret", 32'(mb_ex__instret), 0);
      chk("mis_no_req", 32'(dmem_req), 0);
      if (probe) begin
        ex_mb__mem_read = 1'b0;
        ex_mb__mem_write = 1'b0;
        ex_mb__alu_y = 32'h77;
        ex_mb__rd_wen = 1'b1;
        #1;
        chk("flush_no_stall", 32'(mb_stall), 0);
        @(negedge clk);
        chk("flush_no_wb", 32'(mb_wb__valid), 0);
        chk("flush_no_instret", 32'(mb_ex__instret), 0);
        chk("flush_no_req", 32'(dmem_req), 0);
      end
      drive_idle();
    end else begin
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
        @(negedge clk);
        chk("busy_req", 32'(dmem_req), 1);
        chk("busy_addr", dmem_addr, y & 32'hFFFF_FFFC);
        chk("busy_we", 32'(dmem_we), 32'(wr));
        if (wr) begin
          chk("busy_wmask", 32'(dmem_wmask), 32'(m_mask(f3, y)));
          chk("busy_wdata", dmem_wdata, m_wdata(f3, rs2));
        end
        if (c == ack_dly) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
          #1;
          chk("ack_stall_low", 32'(mb_stall), 0);
          @(negedge clk);
          dmem_ack = 1'b0;
          dmem_rdata = $urandom;
          drive_idle();
          chk("mem_wb_valid", 32'(mb_wb__valid), 1);
          chk("mem_instret", 32'(mb_ex__instret), 1);
          chk("mem_no_trap", 32'(mb_if__trap_taken), 0);
          chk("mem_req_drop", 32'(dmem_req), 0);
          chk("mem_rd_wen", 32'(mb_wb__rd_wen), 32'(rd && rw));
          chk("stall_cycles", last_stall, ack_dly + 1);
          if (rd) begin
            chk("load_data", mb_wb__rd_wdata, m_load(f3, y, rdata));
            chk("load_rd_addr", 32'(mb_wb__rd_addr), 32'(ra));
          end
          done = 1'b1;
        end else begin
          #1;
          chk("busy_stall", 32'(mb_stall), 1);
          if (mb_stall) last_stall++;
          if (c == TMO - 1) begin
            @(negedge clk);
            drive_idle();
            chk("tmo_trap", 32'(mb_if__trap_taken), 1);
            chk("tmo_src", 32'(mb_ex__trap_src), rd ? 5 : 7);
            chk("tmo_addr", mb_ex__dmem_addr, y);
            chk("tmo_no_wb", 32'(mb_wb__valid), 0);
            chk("tmo_no_wen", 32'(mb_wb__rd_wen), 0);
            chk("tmo_no_instret", 32'(mb_ex__instret), 0);
            chk("tmo_req_drop", 32'(dmem_req), 0);
            dmem_ack = 1'b1;
            @(negedge clk);
            chk("late_ack_no_wb", 32'(mb_wb__valid), 0);
            chk("late_ack_no_instret", 32'(mb_ex__instret), 0);
            chk("late_ack_no_req", 32'(dmem_req), 0);
            dmem_ack = 1'b0;
            done = 1'b1;
          end
        end
      end
      if (!done) chk("busy_bound", 0, 1);
    end
    @(negedge clk);
    chk("pulse_wb_low", 32'(mb_wb__valid), 0);
    chk("pulse_instret_low", 32'(mb_ex__instret), 0);
    chk("pulse_trap_low", 32'(mb_if__trap_taken), 0);
    chk("idle_req_low", 32'(dmem_req), 0);
  endtask

  initial begin
    bit r;
    bit w;
    int kind;
    logic [2:0]  f3;
    logic [31:0] y;

    rst_n = 1'b0;
    drive_idle();
    ex_mb__alu_y = 32'd0;
    ex_mb__rs2_rdata = 32'd0;
    ex_mb__mem_funct3 = 3'b000;
    ex_mb__rd_addr = 5'd0;
    ex_mb__rd_wen = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_wmask", 32'(dmem_wmask), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_stall", 32'(mb_stall), 0);
    chk("rst_wb_valid", 32'(mb_wb__valid), 0);
    chk("rst_rd_wen", 32'(mb_wb__rd_wen), 0);
    chk("rst_wdata_wb", mb_wb__rd_wdata, 0);
    chk("rst_trap", 32'(mb_if__trap_taken), 0);
    chk("rst_trap_src", 32'(mb_ex__trap_src), 0);
    chk("rst_trap_addr", mb_ex__dmem_addr, 0);
    chk("rst_instret", 32'(mb_ex__instret), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-memory op
    exec(0, 0, 3'b000, 32'h1234_5678, 32'd0, 5'd3, 1, 0, 32'd0, 0);

    // LB at 0x103, ack two cycles after the request rises
    exec(1, 0, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 1, 2, 32'h80FF_FFFF, 0);
    chk("lb_stall3", last_stall, 3);

    // SH at 0x202
    exec(0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd9, 1, 1, 32'd0, 0);

    // Misaligned LW with flush of the following instruction
    exec(1, 0, 3'b010, 32'h0000_1001, 32'd0, 5'd4, 1, 0, 32'd0, 1);

    // SW timeout, then SW acked on the last allowed cycle
    exec(0, 1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 5'd1, 1, 99, 32'd0, 0);
    exec(0, 1, 3'b010, 32'h0000_4004, 32'h1357_9BDF, 5'd1, 1, TMO - 1, 32'd0, 0);

    // Reserved funct3 behaves as a word
    exec(1, 0, 3'b110, 32'h0000_0010, 32'd0, 5'd2, 1, 0, 32'h8765_4321, 0);
    exec(1, 0, 3'b111, 32'h0000_0012, 32'd0, 5'd2, 1, 0, 32'd0, 0);

    // Reset in the second BUSY cycle of an LHU
    ex_mb__valid = 1'b1;
    ex_mb__mem_read = 1'b1;
    ex_mb__mem_funct3 = 3'b101;
    ex_mb__alu_y = 32'h0000_0302;
    ex_mb__rd_addr = 5'd6;
    ex_mb__rd_wen = 1'b1;
    @(negedge clk);
    chk("lhu_req", 32'(dmem_req), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_busy_req", 32'(dmem_req), 0);
    chk("rst_busy_stall", 32'(mb_stall), 0);
    chk("rst_busy_wb", 32'(mb_wb__valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("rst_late_ack_wb", 32'(mb_wb__valid), 0);
    chk("rst_late_ack_instret", 32'(mb_ex__instret), 0);
    exec(0, 0, 3'b000, 32'h0000_0005, 32'd0, 5'd8, 1, 0, 32'd0, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      r = (kind == 1);
      w = (kind == 2);
      f3 = 3'($urandom_range(0, 7));
      y = $urandom;
      if ($urandom_range(0, 3) != 0) y = y & ~(32'(m_size(f3)) - 32'd1);
      exec(r, w, f3, y, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
